// File: rtl/uart_alu_seq_pkg.sv
// Shared types for the UART/ALU command sequencer: FSM states, ALU opcodes, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    S_RXA,
    S_RXB,
    S_RXOP,
    S_EXEC,
    S_TX
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Bits needed to index n items, never less than one so counters stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_alu_seq_if.sv
// UART FIFO side of the sequencer: rx pop port and tx push port.
// Latency: n/a (wiring only).
// Backpressure: rx_empty gates rd_uart, tx_full gates wr_uart.
interface uart_alu_seq_if #(
  parameter int DBIT = 8
) ();
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic [DBIT-1:0] w_data;
  logic            wr_uart;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/uart_alu_seq_bytecnt.sv
// Byte index counter shared by the RX and TX phases, with terminal-count flag.
// Latency: count updates on the edge after inc; last is combinational.
// Backpressure: holds its value while inc is low.
module uart_alu_seq_bytecnt
  import uart_alu_pkg::*;
#(
  parameter int NBYTES = 2,
  localparam int CW = clog2_min1(NBYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_seq.sv
// Pops A, B (LSB first) and opcode from the rx FIFO, runs the ALU, pushes result bytes; optional UART_ALU_SEQ_TIMEOUT_EN.
// Latency: 2*NBYTES+1 rx cycles, 1 exec cycle, NBYTES tx cycles; back-to-back frames without idle.
// Backpressure: waits on rx_empty while receiving and on tx_full while transmitting, never drops a byte.
module uart_alu_seq
  import uart_alu_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int NBYTES      = 2,
  parameter int OPW         = 6,
  parameter int TIMEOUT_CYC = 50000000,
  localparam int W  = DBIT * NBYTES,
  localparam int CW = clog2_min1(NBYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_alu_seq_if.master        uart,
  output logic [W-1:0]          dato_A,
  output logic [W-1:0]          dato_B,
  output logic [OPW-1:0]        dato_Op,
  input  logic [W-1:0]          alu_in,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            last, cnt_inc, cnt_clr, expire, in_rx;
  logic [W-1:0]    sh_a, sh_b, result_q;
  logic [DBIT-1:0] w_byte;

  uart_alu_seq_bytecnt #(.NBYTES(NBYTES)) u_bytecnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (last)
  );

  assign in_rx        = state inside {S_RXA, S_RXB, S_RXOP};
  assign uart.rd_uart = ~reset & in_rx & ~uart.rx_empty;
  assign uart.wr_uart = ~reset & (state == S_TX) & ~uart.tx_full;
  assign busy         = ~((state == S_RXA) && (cnt == '0));

  always_ff @(posedge clk) begin
    if (reset) state <= S_RXA;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      S_RXA:  if (uart.rd_uart) begin cnt_inc = 1'b1; if (last) state_n = S_RXB; end
      S_RXB:  if (uart.rd_uart) begin cnt_inc = 1'b1; if (last) state_n = S_RXOP; end
      S_RXOP: if (uart.rd_uart) state_n = S_EXEC;
      S_EXEC: begin state_n = S_TX; cnt_clr = 1'b1; end
      S_TX:   if (uart.wr_uart) begin cnt_inc = 1'b1; if (last) state_n = S_RXA; end
      default: state_n = S_RXA;
    endcase
    if (expire) begin
      state_n = S_RXA;
      cnt_clr = 1'b1;
    end
  end

  // Operands assemble in shadows so the ALU only ever sees complete frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a     <= '0;
      sh_b     <= '0;
      dato_A   <= '0;
      dato_B   <= '0;
      dato_Op  <= '0;
      result_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_TX) && uart.wr_uart && last;
      if (expire) begin
        sh_a <= '0;
        sh_b <= '0;
      end else if (uart.rd_uart) begin
        case (state)
          S_RXA: for (int i = 0; i < NBYTES; i++)
                   if (cnt == CW'(i)) sh_a[i*DBIT +: DBIT] <= uart.r_data;
          S_RXB: for (int i = 0; i < NBYTES; i++)
                   if (cnt == CW'(i)) sh_b[i*DBIT +: DBIT] <= uart.r_data;
          S_RXOP: begin
            dato_A  <= sh_a;
            dato_B  <= sh_b;
            dato_Op <= uart.r_data[OPW-1:0];
          end
          default: ;
        endcase
      end
      if (state == S_EXEC) result_q <= alu_in;
    end
  end

  always_comb begin
    w_byte = result_q[DBIT-1:0];
    if (state == S_TX)
      for (int i = 1; i < NBYTES; i++)
        if (cnt == CW'(i)) w_byte = result_q[i*DBIT +: DBIT];
  end
  assign uart.w_data = w_byte;

`ifdef UART_ALU_SEQ_TIMEOUT_EN
  localparam int TW = clog2_min1(TIMEOUT_CYC);
  logic [TW-1:0] idle_cnt;
  logic          idle;

  // A byte accepted on the expiry cycle makes idle low, so the byte wins.
  assign idle        = ~reset & busy & in_rx & uart.rx_empty;
  assign expire      = idle && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = expire;

  always_ff @(posedge clk) begin
    if (reset || !idle || expire) idle_cnt <= '0;
    else                          idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_seq.sv
// Bench for uart_alu_seq: queue-modelled FIFOs, A+B ALU, directed and random frames on NBYTES=2 and NBYTES=1 instances.
module tb_uart_alu_seq;
  import uart_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rst1;
  logic [15:0] a2, b2, alu2;
  logic [5:0]  op2, op1;
  logic        busy2, done2, terr2, busy1, done1, terr1;
  logic [7:0]  a1, b1, alu1;

  uart_alu_seq_if #(.DBIT(8)) u2 ();
  uart_alu_seq_if #(.DBIT(8)) u1 ();

  assign alu2 = a2 + b2;
  assign alu1 = a1 + b1;

  uart_alu_seq #(.DBIT(8), .NBYTES(2), .OPW(6), .TIMEOUT_CYC(20)) dut2 (
    .clk(clk), .reset(rst2), .uart(u2), .dato_A(a2), .dato_B(b2), .dato_Op(op2),
    .alu_in(alu2), .busy(busy2), .done(done2), .timeout_err(terr2));

  uart_alu_seq #(.DBIT(8), .NBYTES(1), .OPW(6), .TIMEOUT_CYC(20)) dut1 (
    .clk(clk), .reset(rst1), .uart(u1), .dato_A(a1), .dato_B(b1), .dato_Op(op1),
    .alu_in(alu1), .busy(busy1), .done(done1), .timeout_err(terr1));

  logic [7:0]  q2[$], q1[$], out2[$], out1[$], eo2[$], eo1[$];
  logic [37:0] etri[$];
  logic [37:0] prev_tri, cur_tri;
  int          done2_cyc[$], rd2_cyc[$], terr_cyc[$];
  int          cyc, checks, failures, bad_wr, tri_bad, done1_n, terr_total;
  bit          hold2, txf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO heads, sample just after the falling edge, advance.
  task automatic step();
    u2.rx_empty = hold2 || (q2.size() == 0);
    u2.r_data   = (q2.size() != 0) ? q2[0] : 8'h00;
    u2.tx_full  = txf;
    u1.rx_empty = (q1.size() == 0);
    u1.r_data   = (q1.size() != 0) ? q1[0] : 8'h00;
    u1.tx_full  = txf;
    #1;
    if (u2.rd_uart) begin void'(q2.pop_front()); rd2_cyc.push_back(cyc); end
    if (u2.wr_uart) out2.push_back(u2.w_data);
    if (u2.wr_uart && txf) bad_wr++;
    if (done2) done2_cyc.push_back(cyc);
    if (terr2 || terr1) begin terr_cyc.push_back(cyc); terr_total++; end
    if (u1.rd_uart) void'(q1.pop_front());
    if (u1.wr_uart) out1.push_back(u1.w_data);
    if (u1.wr_uart && txf) bad_wr++;
    if (done1) done1_n++;
    cur_tri = {a2, b2, op2};
    if (rst2) prev_tri = cur_tri;
    else if (cur_tri !== prev_tri) begin
      if (etri.size() == 0) tri_bad++;
      else if (etri.pop_front() !== cur_tri) tri_bad++;
      prev_tri = cur_tri;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_frame2(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb);
    logic [15:0] r;
    q2.push_back(a[7:0]); q2.push_back(a[15:8]);
    q2.push_back(b[7:0]); q2.push_back(b[15:8]);
    q2.push_back(opb);
    etri.push_back({a, b, opb[5:0]});
    r = a + b;
    eo2.push_back(r[7:0]); eo2.push_back(r[15:8]);
  endtask

  task automatic push_frame1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    logic [7:0] r;
    q1.push_back(a); q1.push_back(b); q1.push_back(opb);
    r = a + b;
    eo1.push_back(r);
  endtask

  task automatic do_reset2();
    rst2 = 1'b1; step(); step(); rst2 = 1'b0;
    q2.delete(); out2.delete(); eo2.delete(); etri.delete();
    done2_cyc.delete(); rd2_cyc.delete(); terr_cyc.delete();
    bad_wr = 0; tri_bad = 0;
  endtask

  task automatic run_until(input int n2, input int n1, input int budget);
    int k;
    k = 0;
    while ((out2.size() < n2 || out1.size() < n1) && k < budget) begin step(); k++; end
    chk("out_budget", (k < budget), 1);
    repeat (3) step();
  endtask

  task automatic cmp_out2(input string tag);
    chk({tag, "_len"}, out2.size(), eo2.size());
    for (int i = 0; i < out2.size() && i < eo2.size(); i++) chk({tag, "_byte"}, out2[i], eo2[i]);
    chk({tag, "_atomic"}, tri_bad, 0);
    chk({tag, "_tri_left"}, etri.size(), 0);
  endtask

  initial begin
    int s, t0, nfr;
    cyc = 0; checks = 0; failures = 0; bad_wr = 0; tri_bad = 0; done1_n = 0; terr_total = 0;
    hold2 = 0; txf = 0; rst2 = 1'b1; rst1 = 1'b1; prev_tri = '0;
    q2.push_back(8'h5A); q1.push_back(8'hA5);
    @(negedge clk);
    step(); step();
    chk("rst_rd2", u2.rd_uart, 0); chk("rst_wr2", u2.wr_uart, 0);
    chk("rst_busy2", busy2, 0);    chk("rst_done2", done2, 0);
    chk("rst_A2", a2, 0); chk("rst_B2", b2, 0); chk("rst_Op2", op2, 0);
    chk("rst_wdata2", u2.w_data, 0); chk("rst_terr2", terr2, 0);
    chk("rst_rd1", u1.rd_uart, 0); chk("rst_wr1", u1.wr_uart, 0); chk("rst_done1", done1, 0);
    q2.delete(); q1.delete(); rst1 = 1'b0;
    do_reset2();

    // Single frame: 34 12 01 01 20.
    s = cyc;
    push_frame2(16'h1234, 16'h0101, {2'b00, OP_ADD});
    run_until(2, 0, 40);
    cmp_out2("frame1");
    chk("frame1_A", a2, 16'h1234); chk("frame1_B", b2, 16'h0101); chk("frame1_Op", op2, 6'h20);
    chk("frame1_done_n", done2_cyc.size(), 1);
    if (done2_cyc.size() > 0) chk("frame1_latency", done2_cyc[0] - s, 8);

    // Two preloaded frames, the second wraps to zero.
    do_reset2();
    push_frame2(16'h1234, 16'h0101, {2'b00, OP_ADD});
    push_frame2(16'hFFFF, 16'h0001, {2'b00, OP_ADD});
    run_until(4, 0, 60);
    cmp_out2("two");
    chk("two_done_n", done2_cyc.size(), 2);
    if (done2_cyc.size() == 2 && rd2_cyc.size() == 10) begin
      chk("two_rd_resume", rd2_cyc[5], done2_cyc[0]);
      chk("two_gap", done2_cyc[1] - done2_cyc[0], 8);
    end else chk("two_logs", rd2_cyc.size(), 10);

    // tx FIFO full for ten cycles of the transmit phase.
    do_reset2();
    txf = 1;
    push_frame2(16'h1234, 16'h0101, {2'b00, OP_ADD});
    repeat (16) step();
    chk("txfull_nowr", out2.size(), 0);
    chk("txfull_busy", busy2, 1);
    txf = 0;
    run_until(2, 0, 20);
    cmp_out2("txfull");
    chk("txfull_bad_wr", bad_wr, 0);
    chk("txfull_done_n", done2_cyc.size(), 1);

    // Reset after three bytes; the next frame is already queued.
    do_reset2();
    q2.push_back(8'hAA); q2.push_back(8'hBB); q2.push_back(8'hCC);
    repeat (3) step();
    push_frame2(16'h0010, 16'h0005, 8'h22);
    rst2 = 1'b1; step(); step();
    chk("mrst_rd", u2.rd_uart, 0); chk("mrst_wr", u2.wr_uart, 0); chk("mrst_busy", busy2, 0);
    chk("mrst_A", a2, 0); chk("mrst_Op", op2, 0);
    rst2 = 1'b0;
    run_until(2, 0, 40);
    cmp_out2("mrst");

`ifdef UART_ALU_SEQ_TIMEOUT_EN
    // Two bytes then silence: abort after nineteen idle cycles.
    do_reset2();
    q2.push_back(8'hAA); q2.push_back(8'hBB);
    step(); step();
    t0 = cyc;
    repeat (25) step();
    chk("to_pulses", terr_cyc.size(), 1);
    if (terr_cyc.size() > 0) chk("to_cycle", terr_cyc[0] - t0, 19);
    chk("to_idle", busy2, 0);
    push_frame2(16'h0010, 16'h0005, 8'h22);
    run_until(2, 0, 40);
    cmp_out2("to_after");
    // A byte arriving exactly on the expiry cycle prevents the abort.
    do_reset2();
    push_frame2(16'h1234, 16'h0101, {2'b00, OP_ADD});
    step(); step();
    hold2 = 1; repeat (19) step(); hold2 = 0;
    run_until(2, 0, 40);
    chk("to_race_pulses", terr_cyc.size(), 0);
    cmp_out2("to_race");
`endif

    // Random frames with random rx gaps and tx stalls.
    do_reset2();
    nfr = 12;
    for (int f = 0; f < nfr; f++)
      push_frame2(16'($urandom), 16'($urandom), 8'($urandom));
    s = 0;
    while (out2.size() < 2 * nfr && s < 2000) begin
      hold2 = ($urandom_range(0, 3) == 0);
      txf   = ($urandom_range(0, 3) == 0);
      step(); s++;
    end
    hold2 = 0; txf = 0;
    run_until(2 * nfr, 0, 20);
    cmp_out2("rand");
    chk("rand_done_n", done2_cyc.size(), nfr);
    chk("rand_bad_wr", bad_wr, 0);

    // Single-byte operands.
    push_frame1(8'h07, 8'h03, 8'h22);
    run_until(0, 1, 30);
    chk("nb1_len", out1.size(), 1);
    if (out1.size() > 0) chk("nb1_byte", out1[0], 8'h0A);
    chk("nb1_done_n", done1_n, 1);
    chk("nb1_A", a1, 8'h07); chk("nb1_B", b1, 8'h03); chk("nb1_Op", op1, 6'h22);
    out1.delete(); eo1.delete(); done1_n = 0;
    for (int f = 0; f < 8; f++) push_frame1(8'($urandom), 8'($urandom), 8'($urandom));
    s = 0;
    while (out1.size() < 8 && s < 1000) begin
      txf = ($urandom_range(0, 2) == 0);
      step(); s++;
    end
    txf = 0;
    run_until(0, 8, 20);
    chk("nb1r_len", out1.size(), 8);
    for (int i = 0; i < out1.size() && i < eo1.size(); i++) chk("nb1r_byte", out1[i], eo1[i]);
    chk("nb1r_done_n", done1_n, 8);

`ifndef UART_ALU_SEQ_TIMEOUT_EN
    chk("no_timeout", terr_total, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
